// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host->device over PS/2 and checks the device ACK.
// Latency: clock line pulled 1 cycle after acceptance; status pulse 2 cycles after the
//          synchronised line goes idle. Backpressure: tx_ready only in IDLE, no queueing.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   tx_data, tx_valid     command byte and request (accepted when tx_valid & tx_ready)
//   tx_ready, busy        ready only in IDLE; busy in every other state
//   done, ack_err,        one-cycle status pulses, mutually exclusive, asserted on the
//   timeout               last busy cycle (tx_ready rises on the following cycle)
//   kbdclk_in, kbddat_in  raw PS/2 pin levels (asynchronous to clk)
//   kbdclk_oe, kbddat_oe  open-drain enables, 1 pulls the line low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,   // must be at least 9 (start bit overlaps last 8)
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  input  logic       kbdclk_in,
  input  logic       kbddat_in,
  output logic       kbdclk_oe,
  output logic       kbddat_oe
);

  // A single flop is never enough against metastability on the raw pins.
  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DAT  = INH_W'(INHIBIT_CYCLES - 8);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. They reset to 1 (idle bus level) so that coming out of
  // reset never manufactures a falling edge.
  // ---------------------------------------------------------------------------
  logic [SS-1:0] clk_sync_q;
  logic [SS-1:0] dat_sync_q;
  logic          clk_hist_q;
  logic          sync_clk;
  logic          sync_dat;
  logic          fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_hist_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SS-2:0], kbdclk_in};
      dat_sync_q <= {dat_sync_q[SS-2:0], kbddat_in};
      clk_hist_q <= clk_sync_q[SS-1];
    end
  end

  assign sync_clk = clk_sync_q[SS-1];
  assign sync_dat = dat_sync_q[SS-1];
  assign fall     = clk_hist_q & ~sync_clk;

  // ---------------------------------------------------------------------------
  // Transfer state
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q,     state_d;
  logic [INH_W-1:0] inh_cnt_q,   inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
  logic [3:0]       bit_cnt_q,   bit_cnt_d;
  logic [9:0]       shift_q,     shift_d;     // {stop, parity, D7..D0}
  logic             ack_ok_q,    ack_ok_d;
  logic             idle_seen_q, idle_seen_d; // line was idle on the previous cycle
  logic             clk_oe_q,    clk_oe_d;
  logic             dat_oe_q,    dat_oe_d;

  logic line_idle;
  logic tmo_phase;
  logic tmo_hit;

  assign tx_ready  = (state_q == S_IDLE);
  assign busy      = ~tx_ready;
  assign kbdclk_oe = clk_oe_q;
  assign kbddat_oe = dat_oe_q;

  assign line_idle = sync_clk & sync_dat;
  // Only the device-paced phases are guarded; INHIBIT has a fixed length.
  assign tmo_phase = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign tmo_hit   = tmo_phase && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    inh_cnt_d   = inh_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_ok_d    = ack_ok_q;
    idle_seen_d = 1'b0;
    clk_oe_d    = 1'b0;
    dat_oe_d    = 1'b0;
    done        = 1'b0;
    ack_err     = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      S_IDLE: begin
        inh_cnt_d = '0;
        tmo_cnt_d = '0;
        if (tx_valid && tx_ready) begin
          shift_d  = {1'b1, ~^tx_data, tx_data};
          state_d  = S_INHIBIT;
          clk_oe_d = 1'b1;
        end
      end

      S_INHIBIT: begin
        // Outputs are registered, so they are decided from the next count value.
        clk_oe_d  = 1'b1;
        inh_cnt_d = inh_cnt_q + 1'b1;
        dat_oe_d  = (inh_cnt_d >= INH_DAT);
        if (inh_cnt_q == INH_LAST) begin
          state_d   = S_RELEASE;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
        end
      end

      S_RELEASE: begin
        // Start bit stays on the data line while the device takes over the clock.
        bit_cnt_d = '0;
        tmo_cnt_d = '0;
        dat_oe_d  = 1'b1;
        state_d   = S_SEND;
      end

      S_SEND: begin
        dat_oe_d  = dat_oe_q;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (fall) begin
          tmo_cnt_d = '0;
          dat_oe_d  = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          // The tenth fall puts the stop bit (line released) on the wire.
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (fall) begin
          tmo_cnt_d = '0;
          ack_ok_d  = ~sync_dat;
          state_d   = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        tmo_cnt_d   = fall ? '0 : tmo_cnt_q + 1'b1;
        idle_seen_d = line_idle;
        if (line_idle && idle_seen_q) begin
          state_d = S_IDLE;
          done    = ack_ok_q;
          ack_err = ~ack_ok_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the phase decided, including a coincident done.
    if (tmo_hit) begin
      state_d     = S_IDLE;
      tmo_cnt_d   = '0;
      idle_seen_d = 1'b0;
      clk_oe_d    = 1'b0;
      dat_oe_d    = 1'b0;
      done        = 1'b0;
      ack_err     = 1'b0;
      timeout     = 1'b1;
    end
  end

  // Reset releases both lines without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      inh_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ack_ok_q    <= 1'b0;
      idle_seen_q <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_ok_q    <= ack_ok_d;
      idle_seen_q <= idle_seen_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TMO  = 600;
  localparam int HALF = 15;   // device half clock period in system cycles

  localparam logic [2:0] ST_NONE = 3'b000;
  localparam logic [2:0] ST_DONE = 3'b001;
  localparam logic [2:0] ST_AERR = 3'b010;
  localparam logic [2:0] ST_TMO  = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_err, timeout;
  logic       kbdclk_in, kbddat_in, kbdclk_oe, kbddat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int dev_pulses = 0;

  logic [2:0]  exp_status_q[$];
  logic [10:0] exp_frame_q[$];
  logic [2:0]  code;
  logic [2:0]  exp_code;

  // Open-drain wired-AND of host and device
  assign kbdclk_in = ~(kbdclk_oe | dev_clk_low);
  assign kbddat_in = ~(kbddat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout(timeout),
    .kbdclk_in(kbdclk_in),
    .kbddat_in(kbddat_in),
    .kbdclk_oe(kbdclk_oe),
    .kbddat_oe(kbddat_oe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Status monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (done || ack_err || timeout)) begin
      code = {timeout, ack_err, done};
      if (exp_status_q.size() == 0) begin
        chk("status_unexpected", {29'd0, code}, 32'd0);
      end else begin
        exp_code = exp_status_q.pop_front();
        chk("status_code", {29'd0, code}, {29'd0, exp_code});
        chk("status_while_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Device model: waits for request-to-send, clocks npulses, samples data on
  // each rising edge, drives ACK during pulse 11 if ack_low.
  task automatic dev_frame(input int npulses, input bit ack_low);
    logic [10:0] f;
    logic [10:0] e;
    int n;
    f = '0;
    n = 0;
    dev_pulses = 0;
    @(negedge clk);
    while (!(!kbdclk_oe && kbddat_oe) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      chk("dev_rts_seen", 32'd0, 32'd1);
    end else begin
      f[0] = kbddat_in;
      for (int p = 1; p <= npulses; p++) begin
        if (p == 11) dev_dat_low = ack_low;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (p <= 10) f[p] = kbddat_in;
        dev_pulses = p;
      end
      dev_dat_low = 1'b0;
      if (npulses == 11) begin
        if (exp_frame_q.size() == 0) begin
          chk("frame_unexpected", {21'd0, f}, 32'd0);
        end else begin
          e = exp_frame_q.pop_front();
          chk("frame_parity", {31'd0, f[9]}, {31'd0, e[9]});
          chk("frame_bits", {21'd0, f}, {21'd0, e});
        end
      end
    end
  endtask

  // Issue one command; measures the inhibit phase and returns in RELEASE.
  task automatic send(input logic [7:0] b, input logic [10:0] frame, input logic [2:0] st,
                      input bit push_frame, input bit hold, input logic [7:0] hold_b);
    int n;
    int inh;
    int lead;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, tx_ready}, 32'd1);
    if (push_frame) exp_frame_q.push_back(frame);
    if (st != ST_NONE) exp_status_q.push_back(st);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_clk_oe", {31'd0, kbdclk_oe}, 32'd1);
    chk("accept_busy", {31'd0, busy}, 32'd1);
    if (hold) begin
      tx_data = hold_b;
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
    end
    inh  = 0;
    lead = 0;
    @(negedge clk);
    while (kbdclk_oe && inh < 5000) begin
      inh++;
      if (kbddat_oe) lead++;
      @(negedge clk);
    end
    chk("inhibit_len", inh, INH);
    chk("start_lead", lead, 8);
  endtask

  task automatic wait_status();
    int n;
    n = 0;
    while (exp_status_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("status_seen", exp_status_q.size(), 0);
    exp_status_q.delete();
    @(negedge clk);
    chk("ready_after_status", {31'd0, tx_ready}, 32'd1);
    chk("lines_released", {30'd0, kbdclk_oe, kbddat_oe}, 32'd0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_fail++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_status", {29'd0, done, ack_err, timeout}, 32'd0);
    chk("rst_oe", {30'd0, kbdclk_oe, kbddat_oe}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED set-LEDs, good ACK: frame start0, 1,0,1,1,0,1,1,1, P=1, stop=1
    fork
      dev_frame(11, 1'b1);
      send(8'hED, 11'h7DA, ST_DONE, 1'b1, 1'b0, 8'h00);
    join
    wait_status();
    chk("ed_busy_low", {31'd0, busy}, 32'd0);

    // 0xF4 (parity 0) followed immediately by 0x00 (parity 1)
    fork
      dev_frame(11, 1'b1);
      send(8'hF4, 11'h5E8, ST_DONE, 1'b1, 1'b0, 8'h00);
    join
    wait_status();
    fork
      dev_frame(11, 1'b1);
      send(8'h00, 11'h600, ST_DONE, 1'b1, 1'b0, 8'h00);
    join
    wait_status();

    // Device leaves data high on the ACK clock
    fork
      dev_frame(11, 1'b0);
      send(8'hFF, 11'h7FE, ST_AERR, 1'b1, 1'b0, 8'h00);
    join
    wait_status();
    chk("aerr_busy_low", {31'd0, busy}, 32'd0);

    // tx_valid held with another byte during the transfer
    fork
      dev_frame(11, 1'b1);
      begin
        send(8'h55, 11'h6AA, ST_DONE, 1'b1, 1'b1, 8'hC3);
        n = 0;
        while (dev_pulses < 10 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    join
    wait_status();
    repeat (10) @(negedge clk);
    chk("hold_no_requeue", {31'd0, busy}, 32'd0);

    // Device never clocks: timeout after TMO cycles of SEND
    send(8'h12, 11'h000, ST_TMO, 1'b0, 1'b0, 8'h00);
    n = 0;
    while (!timeout && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_delay", {31'd0, (n >= TMO && n <= TMO + 2)}, 32'd1);
    wait_status();

    // Reset in the middle of bit 4; D3 of 0xF0 is 0 so data is being pulled
    fork
      dev_frame(4, 1'b1);
      send(8'hF0, 11'h000, ST_NONE, 1'b0, 1'b0, 8'h00);
    join
    chk("pre_reset_dat_oe", {31'd0, kbddat_oe}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {30'd0, kbdclk_oe, kbddat_oe}, 32'd0);
    chk("async_rst_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("post_rst_status", {29'd0, done, ack_err, timeout}, 32'd0);

    chk("sb_status_drained", exp_status_q.size(), 0);
    chk("sb_frame_drained", exp_frame_q.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the keyboard link whose receive side feeds the game's Letter decoder.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset, and checks the device ACK.
- Drives kbdclk/kbddat as open-drain lines through output-enable pins; the top level builds the tristate (oe=1 pulls the line low).
- The receiver must ignore the line while busy=1.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles the clock line is held low before the start bit (120 us at 100 MHz; PS/2 minimum is 100 us).
- TIMEOUT_CYCLES, 2000000, clk cycles allowed per transfer phase before abort (20 ms).
- SYNC_STAGES, 2, synchronizer flops on kbdclk_in and kbddat_in (minimum 2).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; the byte is accepted on a cycle where tx_valid=1 and tx_ready=1.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: transfer completed with a good ACK.
- ack_err  out  1  one-cycle pulse: the ACK bit was sampled high.
- timeout  out  1  one-cycle pulse: a phase exceeded TIMEOUT_CYCLES.
- kbdclk_in  in  1  raw PS/2 clock pin level.
- kbddat_in  in  1  raw PS/2 data pin level.
- kbdclk_oe  out  1  1 = pull the PS/2 clock low.
- kbddat_oe  out  1  1 = pull the PS/2 data low.

Behaviour:
- Reset values: state=IDLE, tx_ready=1, busy=0, done=ack_err=timeout=0, kbdclk_oe=0, kbddat_oe=0, all counters 0.
  - Asserting rst_n low mid-transfer releases both lines immediately (asynchronously).
- Inputs pass through SYNC_STAGES flops, plus one history flop on the clock. fall = hist & ~sync_clk.
- Frame: 11 bits after the captured byte: start 0; data bits D0..D7, LSB first; parity P = ~^data (odd); stop 1.
  - The shift register loads {1'b1, P, data} at acceptance.
- States:
  - IDLE: both oe=0. On tx_valid&tx_ready, capture the byte and go to INHIBIT. Counter cleared.
  - INHIBIT: kbdclk_oe=1. In the last 8 cycles of INHIBIT_CYCLES, also kbddat_oe=1 (start bit). When the count reaches INHIBIT_CYCLES, go to RELEASE.
  - RELEASE: kbdclk_oe=0, kbddat_oe=1, bitcnt=0, timeout counter cleared. Go to SEND next cycle.
  - SEND: on each fall, kbddat_oe = ~shift[0], shift right, bitcnt++.
    - Falls 1-8 present D0..D7, fall 9 presents P, fall 10 presents the stop bit (oe=0).
    - After fall 10, go to ACK.
  - ACK: kbddat_oe=0. On the next fall (the 11th), sample sync data.
    - 0 → WAIT_IDLE with ack_ok=1.
    - 1 → WAIT_IDLE with ack_ok=0.
  - WAIT_IDLE: wait until sync clock=1 and sync data=1 for 2 consecutive cycles, then go to IDLE.
    - Pulse done if ack_ok, else ack_err, on the transition cycle.
- Timeout:
  - A counter runs in RELEASE, SEND, ACK and WAIT_IDLE and is cleared on every fall.
  - If it reaches TIMEOUT_CYCLES: release both lines, pulse timeout, go to IDLE. Neither done nor ack_err is pulsed.
- tx_valid while busy is ignored (no queue). tx_data is not sampled after capture.
- Device clock edges seen during IDLE or INHIBIT are ignored; device traffic is pre-empted by the inhibit.
- Priority when done and timeout would coincide: timeout wins. Never pulse two status outputs in the same cycle.
- Latency:
  - Acceptance to the first kbdclk_oe=1: 1 cycle.
  - Line-idle detection to done: SYNC_STAGES+2 cycles.
- tx_ready re-asserts on the cycle after the status pulse.

Test Plan:
- Send 0xED with a device model (clock 12.5 kHz, ACK low):
  - clock held low ≥12000 cycles;
  - on device rising edges, bits sampled = 0,1,0,1,1,0,1,1,1,P=1,stop=1;
  - done pulses once; busy falls.
- Send 0xF4, then immediately send 0x00 after done:
  - parity 0 observed for 0xF4 and 1 for 0x00;
  - second transfer starts only after tx_ready=1.
- Device leaves data high on the 11th fall → ack_err pulses, done stays 0, lines released, state IDLE.
- Device never clocks after RELEASE → timeout pulses after 2000000 cycles; kbdclk_oe=kbddat_oe=0; tx_ready=1.
- rst_n low during SEND bit 4 → oe outputs 0 with no clk edge required; after release, tx_ready=1 and no status pulse.
- tx_valid held with a different byte during a transfer → ignored; the frame carries only the originally captured byte.
